// File: rtl/frame_seq_pkg.sv
// Shared types for the frame acquisition sequencer: state encoding,
// capture modes and the integration/ROI configuration bus.
package frame_seq_pkg;

  localparam int unsigned INT_W  = 16;
  localparam int unsigned ROI_W  = 12;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_GAP
  } seq_state_t;

  localparam logic [MODE_W-1:0] MODE_SINGLE = 2'd0;
  localparam logic [MODE_W-1:0] MODE_BURST  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_CONT   = 2'd2;

  // Integration time plus ROI window, used for both the live and shadow buses
  typedef struct packed {
    logic [INT_W-1:0] integration_time;
    logic [ROI_W-1:0] row_start;
    logic [ROI_W-1:0] row_end;
    logic [ROI_W-1:0] col_start;
    logic [ROI_W-1:0] col_end;
  } roi_cfg_t;

  // A window is usable only when both start coordinates do not exceed their ends
  function automatic logic roi_valid(input roi_cfg_t c);
    return (c.row_start <= c.row_end) && (c.col_start <= c.col_end);
  endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// Loadable down-counter timing the idle gap between frames. done_o is high
// during the last gap cycle so the controller leaves GAP exactly on time.
module seq_gap_timer #(
  parameter int unsigned GAP_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [GAP_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Next count: load takes precedence, otherwise decrement while enabled
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (load_i) begin
      cnt_d  = load_val_i;
      done_d = (load_val_i <= GAP_W'(1));
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d  = cnt_q - GAP_W'(1);
      done_d = (cnt_q <= GAP_W'(2));
    end
  end

  // Counter and done flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/frame_sequencer.sv
// Acquisition controller sequencing the panel timing generator: single,
// burst and continuous capture, per-frame shadowing of integration/ROI
// configuration, inter-frame gap, graceful stop and immediate abort.
// Optional frame watchdog enabled by defining FRAME_TIMEOUT_EN.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned GAP_W = 16
`ifdef FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_W = 24
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [MODE_W-1:0]  cfg_mode,
  input  logic [CNT_W-1:0]   cfg_frame_count,
  input  logic [GAP_W-1:0]   cfg_gap,
  input  logic [INT_W-1:0]   cfg_integration_time,
  input  logic [ROI_W-1:0]   cfg_row_start,
  input  logic [ROI_W-1:0]   cfg_row_end,
  input  logic [ROI_W-1:0]   cfg_col_start,
  input  logic [ROI_W-1:0]   cfg_col_end,
  input  logic               seq_start,
  input  logic               seq_stop,
  input  logic               seq_abort,
  input  logic               tg_frame_busy,
  input  logic               tg_frame_complete,
  output logic               tg_frame_start,
  output logic               tg_frame_reset,
  output logic [INT_W-1:0]   tg_integration_time,
  output logic [ROI_W-1:0]   tg_row_start,
  output logic [ROI_W-1:0]   tg_row_end,
  output logic [ROI_W-1:0]   tg_col_start,
  output logic [ROI_W-1:0]   tg_col_end,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               seq_aborted,
  output logic               cfg_error,
  output logic [CNT_W-1:0]   frames_done
);

  seq_state_t       state_q, state_d;
  logic             stop_q, stop_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  roi_cfg_t         shadow_q, shadow_d;
  roi_cfg_t         cfg_in;

  logic start_q, start_d;
  logic reset_q, reset_d;
  logic done_q, done_d;
  logic aborted_q, aborted_d;
  logic err_q, err_d;
  logic busy_q;

  logic             gap_load, gap_en, gap_done;
  logic [CNT_W-1:0] frames_inc;
  logic             last_frame;
  logic             kill;

  assign cfg_in = '{integration_time: cfg_integration_time,
                    row_start:        cfg_row_start,
                    row_end:          cfg_row_end,
                    col_start:        cfg_col_start,
                    col_end:          cfg_col_end};

  assign frames_inc = frames_q + CNT_W'(1);

  // A completing frame ends the sequence for single/mode 3, the last burst frame, or a pending stop
  assign last_frame = stop_q || seq_stop ||
                      ((cfg_mode == MODE_BURST) ? (frames_inc == cfg_frame_count)
                                                : (cfg_mode != MODE_CONT));

`ifdef FRAME_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 in_frame;

  assign in_frame = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);

  // Watchdog counts frame cycles and restarts as each frame is issued
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == ST_LOAD) begin
      wdog_d = '0;
    end else if (in_frame) begin
      wdog_d = wdog_q + TIMEOUT_W'(1);
    end
  end

  // Watchdog register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign kill = seq_abort || (in_frame && (wdog_q == WDOG_LAST));
`else
  assign kill = seq_abort;
`endif

  seq_gap_timer #(
    .GAP_W (GAP_W)
  ) u_gap_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (gap_load),
    .load_val_i (cfg_gap),
    .en_i       (gap_en),
    .done_o     (gap_done)
  );

  // Next-state and registered-output decode; abort beats completion beats stop
  always_comb begin
    state_d   = state_q;
    stop_d    = stop_q;
    frames_d  = frames_q;
    shadow_d  = shadow_q;
    start_d   = 1'b0;
    reset_d   = 1'b0;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    err_d     = 1'b0;
    gap_load  = 1'b0;
    gap_en    = 1'b0;

    if (state_q == ST_IDLE) begin
      if (seq_start) begin
        if (!roi_valid(cfg_in)) begin
          err_d = 1'b1;
        end else if ((cfg_mode == MODE_BURST) && (cfg_frame_count == '0)) begin
          done_d = 1'b1;
        end else begin
          frames_d = '0;
          stop_d   = 1'b0;
          state_d  = ST_LOAD;
        end
      end
    end else if (kill) begin
      reset_d   = 1'b1;
      aborted_d = 1'b1;
      stop_d    = 1'b0;
      state_d   = ST_IDLE;
    end else begin
      if (seq_stop) begin
        stop_d = 1'b1;
      end
      case (state_q)
        ST_LOAD: begin
          shadow_d = cfg_in;
          start_d  = 1'b1;
          state_d  = ST_START;
        end
        ST_START: begin
          state_d = ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          if (tg_frame_complete) begin
            frames_d = frames_inc;
            if (last_frame) begin
              done_d  = 1'b1;
              stop_d  = 1'b0;
              state_d = ST_IDLE;
            end else if (cfg_gap == '0) begin
              state_d = ST_LOAD;
            end else begin
              gap_load = 1'b1;
              state_d  = ST_GAP;
            end
          end else if ((state_q == ST_WAIT_BUSY) && tg_frame_busy) begin
            state_d = ST_WAIT_DONE;
          end
        end
        ST_GAP: begin
          if (seq_stop) begin
            done_d  = 1'b1;
            stop_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            gap_en = 1'b1;
            if (gap_done) begin
              state_d = ST_LOAD;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      stop_q    <= 1'b0;
      frames_q  <= '0;
      shadow_q  <= '0;
      start_q   <= 1'b0;
      reset_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stop_q    <= stop_d;
      frames_q  <= frames_d;
      shadow_q  <= shadow_d;
      start_q   <= start_d;
      reset_q   <= reset_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  assign tg_frame_start      = start_q;
  assign tg_frame_reset      = reset_q;
  assign tg_integration_time = shadow_q.integration_time;
  assign tg_row_start        = shadow_q.row_start;
  assign tg_row_end          = shadow_q.row_end;
  assign tg_col_start        = shadow_q.col_start;
  assign tg_col_end          = shadow_q.col_end;
  assign seq_busy            = busy_q;
  assign seq_done            = done_q;
  assign seq_aborted         = aborted_q;
  assign cfg_error           = err_q;
  assign frames_done         = frames_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Self-checking bench for frame_sequencer: the bench plays the timing
// generator and predicts every sequence outcome from the capture rules.
module tb_frame_sequencer;
  import frame_seq_pkg::*;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned GAP_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [MODE_W-1:0] cfg_mode = '0;
  logic [CNT_W-1:0]  cfg_frame_count = '0;
  logic [GAP_W-1:0]  cfg_gap = '0;
  logic [INT_W-1:0]  cfg_integration_time = '0;
  logic [ROI_W-1:0]  cfg_row_start = '0, cfg_row_end = '0, cfg_col_start = '0, cfg_col_end = '0;
  logic              seq_start = 1'b0, seq_stop = 1'b0, seq_abort = 1'b0;
  logic              tg_frame_busy = 1'b0, tg_frame_complete = 1'b0;
  logic              tg_frame_start, tg_frame_reset;
  logic [INT_W-1:0]  tg_integration_time;
  logic [ROI_W-1:0]  tg_row_start, tg_row_end, tg_col_start, tg_col_end;
  logic              seq_busy, seq_done, seq_aborted, cfg_error;
  logic [CNT_W-1:0]  frames_done;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_done = 0, n_abort = 0, n_reset = 0, n_err = 0;
  int last_fd = 0;

  always #5 clk = ~clk;

  frame_sequencer #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .cfg_mode             (cfg_mode),
    .cfg_frame_count      (cfg_frame_count),
    .cfg_gap              (cfg_gap),
    .cfg_integration_time (cfg_integration_time),
    .cfg_row_start        (cfg_row_start),
    .cfg_row_end          (cfg_row_end),
    .cfg_col_start        (cfg_col_start),
    .cfg_col_end          (cfg_col_end),
    .seq_start            (seq_start),
    .seq_stop             (seq_stop),
    .seq_abort            (seq_abort),
    .tg_frame_busy        (tg_frame_busy),
    .tg_frame_complete    (tg_frame_complete),
    .tg_frame_start       (tg_frame_start),
    .tg_frame_reset       (tg_frame_reset),
    .tg_integration_time  (tg_integration_time),
    .tg_row_start         (tg_row_start),
    .tg_row_end           (tg_row_end),
    .tg_col_start         (tg_col_start),
    .tg_col_end           (tg_col_end),
    .seq_busy             (seq_busy),
    .seq_done             (seq_done),
    .seq_aborted          (seq_aborted),
    .cfg_error            (cfg_error),
    .frames_done          (frames_done)
  );

  // Pulse counters: each posedge tallies the value held during the previous cycle
  always @(posedge clk) begin
    if (tg_frame_start === 1'b1) n_start++;
    if (seq_done === 1'b1)       n_done++;
    if (seq_aborted === 1'b1)    n_abort++;
    if (tg_frame_reset === 1'b1) n_reset++;
    if (cfg_error === 1'b1)      n_err++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and retire one-cycle request pulses
  task automatic step();
    @(negedge clk);
    seq_start         = 1'b0;
    seq_stop          = 1'b0;
    seq_abort         = 1'b0;
    tg_frame_complete = 1'b0;
  endtask

  function automatic roi_cfg_t cur_cfg();
    return '{integration_time: cfg_integration_time, row_start: cfg_row_start,
             row_end: cfg_row_end, col_start: cfg_col_start, col_end: cfg_col_end};
  endfunction

  function automatic logic [63:0] shadow_out();
    return {tg_integration_time, tg_row_start, tg_row_end, tg_col_start, tg_col_end};
  endfunction

  task automatic rand_roi();
    int a, b;
    cfg_integration_time = INT_W'($urandom);
    a = $urandom_range(0, 4095); b = $urandom_range(a, 4095);
    cfg_row_start = ROI_W'(a); cfg_row_end = ROI_W'(b);
    a = $urandom_range(0, 4095); b = $urandom_range(a, 4095);
    cfg_col_start = ROI_W'(a); cfg_col_end = ROI_W'(b);
  endtask

  // One complete capture sequence with the bench acting as timing generator.
  // Frame count, pulse totals and frame spacing are predicted from the rules.
  task automatic run_seq(input logic [1:0] mode, input int count, input int gap,
                         input int stop_frame, input int abort_frame,
                         input bit stop_in_gap, input string tag);
    int       fd, nat, issued, delay, s0, d0, a0, r0;
    bit       ended, aborted;
    roi_cfg_t shadow;
    cfg_mode        = mode;
    cfg_frame_count = CNT_W'(count);
    cfg_gap         = GAP_W'(gap);
    rand_roi();
    nat     = (mode == 2'd1) ? count : ((mode == 2'd2) ? 32'h3fff_ffff : 1);
    s0 = n_start; d0 = n_done; a0 = n_abort; r0 = n_reset;
    fd = 0; issued = 0; ended = 0; aborted = 0;
    seq_start = 1'b1;
    delay = 2;
    for (int f = 1; !ended; f++) begin
      shadow = cur_cfg();
      repeat (delay) step();
      issued++;
      chk({tag, " frame_start"}, 64'(tg_frame_start), 64'd1);
      chk({tag, " shadow_load"}, shadow_out(), 64'(shadow));
      chk({tag, " busy_in_frame"}, 64'(seq_busy), 64'd1);
      rand_roi();
      if ($urandom_range(0, 3) == 0) seq_start = 1'b1;
      step();
      if (f == abort_frame) begin
        seq_abort = 1'b1;
        step();
        chk({tag, " abort_reset"}, 64'(tg_frame_reset), 64'd1);
        chk({tag, " abort_flag"}, 64'(seq_aborted), 64'd1);
        chk({tag, " abort_idle"}, 64'(seq_busy), 64'd0);
        chk({tag, " abort_frames_held"}, 64'(frames_done), 64'(fd));
        aborted = 1; ended = 1;
      end else begin
        if (f == stop_frame) seq_stop = 1'b1;
        step();
        if ($urandom_range(0, 3) != 0) begin
          tg_frame_busy = 1'b1;
          repeat ($urandom_range(1, 4)) step();
        end
        tg_frame_busy     = 1'b0;
        tg_frame_complete = 1'b1;
        chk({tag, " shadow_held"}, shadow_out(), 64'(shadow));
        step();
        fd++;
        chk({tag, " frames_done"}, 64'(frames_done), 64'(fd));
        if (fd >= nat || f == stop_frame) begin
          chk({tag, " seq_done"}, 64'(seq_done), 64'd1);
          chk({tag, " idle_after_done"}, 64'(seq_busy), 64'd0);
          ended = 1;
        end else begin
          chk({tag, " no_early_done"}, 64'(seq_done), 64'd0);
          if (stop_in_gap && gap >= 2) begin
            seq_stop = 1'b1;
            step();
            chk({tag, " gap_stop_done"}, 64'(seq_done), 64'd1);
            chk({tag, " gap_stop_idle"}, 64'(seq_busy), 64'd0);
            chk({tag, " gap_stop_frames"}, 64'(frames_done), 64'(fd));
            ended = 1;
          end
          delay = gap + 1;
        end
      end
    end
    step(); step();
    chk({tag, " start_pulses"}, 64'(n_start - s0), 64'(issued));
    chk({tag, " done_pulses"}, 64'(n_done - d0), aborted ? 64'd0 : 64'd1);
    chk({tag, " abort_pulses"}, 64'(n_abort - a0), aborted ? 64'd1 : 64'd0);
    chk({tag, " reset_pulses"}, 64'(n_reset - r0), aborted ? 64'd1 : 64'd0);
    last_fd = fd;
  endtask

  initial begin
    int s0, d0, e0, a0, r0;
    int mode, cnt, gap, stp, abt, nat;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("reset_busy", 64'(seq_busy), 64'd0);
    chk("reset_frames", 64'(frames_done), 64'd0);
    chk("reset_shadow", shadow_out(), 64'd0);
    chk("reset_pulses", 64'({tg_frame_start, tg_frame_reset, seq_done, seq_aborted, cfg_error}), 64'd0);

    run_seq(2'd0, 0, 0, 0, 0, 1'b0, "single");
    run_seq(2'd1, 3, 5, 0, 0, 1'b0, "burst3");
    run_seq(2'd2, 0, 3, 2, 0, 1'b0, "cont_stop2");
    run_seq(2'd2, 0, 2, 0, 1, 1'b0, "cont_abort1");
    run_seq(2'd2, 0, 4, 0, 0, 1'b1, "cont_gapstop");
    run_seq(2'd3, 0, 0, 0, 0, 1'b0, "mode3_single");

    // Rejected start: inverted row window
    s0 = n_start; e0 = n_err;
    cfg_mode = 2'd0; rand_roi(); cfg_row_start = 12'd5; cfg_row_end = 12'd2;
    seq_start = 1'b1;
    step();
    chk("cfg_error_pulse", 64'(cfg_error), 64'd1);
    chk("cfg_error_idle", 64'(seq_busy), 64'd0);
    repeat (4) step();
    chk("cfg_error_no_start", 64'(n_start - s0), 64'd0);
    chk("cfg_error_once", 64'(n_err - e0), 64'd1);

    // Empty burst completes at once with no frame
    s0 = n_start; d0 = n_done;
    cfg_mode = 2'd1; cfg_frame_count = '0; rand_roi();
    seq_start = 1'b1;
    step();
    chk("burst0_done", 64'(seq_done), 64'd1);
    chk("burst0_idle", 64'(seq_busy), 64'd0);
    chk("burst0_frames", 64'(frames_done), 64'(last_fd));
    repeat (4) step();
    chk("burst0_no_start", 64'(n_start - s0), 64'd0);
    chk("burst0_done_once", 64'(n_done - d0), 64'd1);

    // Stop and abort are ignored while idle
    a0 = n_abort; r0 = n_reset; d0 = n_done;
    seq_stop = 1'b1; seq_abort = 1'b1;
    step(); step(); step();
    chk("idle_ignore", 64'({n_abort - a0, n_reset - r0, n_done - d0}), 64'd0);
    chk("idle_ignore_busy", 64'(seq_busy), 64'd0);

    for (int i = 0; i < 25; i++) begin
      mode = $urandom_range(0, 3);
      cnt  = $urandom_range(1, 4);
      gap  = $urandom_range(0, 6);
      nat  = (mode == 1) ? cnt : ((mode == 2) ? 4 : 1);
      stp  = (mode == 2) ? $urandom_range(1, 3) : (($urandom_range(0, 2) == 0) ? $urandom_range(1, nat) : 0);
      abt  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nat) : 0;
      run_seq(2'(mode), cnt, gap, stp, abt, 1'($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-frame: back to idle, no generator reset pulse
    r0 = n_reset;
    cfg_mode = 2'd2; cfg_gap = '0; rand_roi();
    seq_start = 1'b1;
    repeat (3) step();
    tg_frame_busy = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("areset_busy", 64'(seq_busy), 64'd0);
    chk("areset_frames", 64'(frames_done), 64'd0);
    chk("areset_shadow", shadow_out(), 64'd0);
    tg_frame_busy = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step();
    chk("areset_no_tg_reset", 64'(n_reset - r0), 64'd0);
    chk("areset_idle", 64'(seq_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
- Acquisition controller that sequences the panel timing_generator.
- Runs single, N-frame burst or continuous captures.
- Shadows the integration/ROI configuration at each frame boundary so software can update registers mid-sequence without corrupting a frame in flight.
- Inserts a programmable inter-frame gap, and handles graceful stop and immediate abort.

Parameters:
- CNT_W, 16, width of frame count and frames-done counter
- GAP_W, 16, width of inter-frame gap counter (clk cycles)
- TIMEOUT_W, 24, width of frame watchdog counter (used only with FRAME_TIMEOUT_EN)

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cfg_mode  input  2  0=single, 1=burst, 2=continuous, 3=treated as single
- cfg_frame_count  input  CNT_W  frames per burst (mode 1 only)
- cfg_gap  input  GAP_W  idle cycles between frames
- cfg_integration_time  input  16  integration time forwarded to generator
- cfg_row_start, cfg_row_end, cfg_col_start, cfg_col_end  input  12 each  ROI
- seq_start  input  1  one-cycle start request
- seq_stop  input  1  one-cycle request: finish current frame, then stop
- seq_abort  input  1  one-cycle request: stop immediately
- tg_frame_busy  input  1  from timing_generator
- tg_frame_complete  input  1  one-cycle pulse from timing_generator
- tg_frame_start  output  1  one-cycle start pulse to generator
- tg_frame_reset  output  1  one-cycle reset pulse to generator
- tg_integration_time  output  16  shadowed integration time
- tg_row_start, tg_row_end, tg_col_start, tg_col_end  output  12 each  shadowed ROI
- seq_busy  output  1  high in any state except IDLE
- seq_done  output  1  one-cycle pulse on normal sequence end
- seq_aborted  output  1  one-cycle pulse on abort or timeout
- cfg_error  output  1  one-cycle pulse on rejected start
- frames_done  output  CNT_W  frames completed in current/last sequence

Behaviour:
- Reset: all outputs 0; state IDLE; stop_pending cleared.
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE:
  - On seq_start, validate config: row_start<=row_end and col_start<=col_end.
  - Invalid config: cfg_error pulses next cycle; stay IDLE.
  - Burst with cfg_frame_count==0: seq_done pulses next cycle; no frame issued.
  - Otherwise: frames_done cleared to 0, go to LOAD.
- LOAD: latch all cfg_* into the tg_* shadow registers (one cycle), go to START.
- START: tg_frame_start=1 for exactly this cycle, go to WAIT_BUSY. Latency from seq_start sampled to tg_frame_start is 2 cycles.
- WAIT_BUSY: wait for tg_frame_busy=1, then go to WAIT_DONE. tg_frame_complete in this state also counts as frame end.
- WAIT_DONE: on tg_frame_complete, frames_done+1 (wraps at 2^CNT_W). End sequence if any of:
  - mode single
  - burst and frames_done+1==cfg_frame_count
  - stop_pending
- On end: seq_done pulse, return to IDLE.
- Otherwise: go to GAP, or straight to LOAD if cfg_gap==0.
- GAP: count cfg_gap cycles (value sampled on entry), then go to LOAD. Shadows are reloaded for every frame.
- seq_stop in any non-IDLE state sets stop_pending:
  - In GAP it ends the sequence immediately with seq_done.
  - In IDLE it is ignored.
- seq_abort in any non-IDLE state: tg_frame_reset pulses next cycle, seq_aborted pulses, go to IDLE; frames_done is held. In IDLE, seq_abort is ignored.
- Priority in the same cycle: abort > tg_frame_complete > stop. seq_start is ignored while seq_busy.
- Asynchronous reset mid-sequence returns to IDLE with outputs 0. No tg_frame_reset pulse is generated; the generator shares the same reset.

Optional Feature:
- FRAME_TIMEOUT_EN defined:
  - Watchdog counts cycles in WAIT_BUSY and WAIT_DONE.
  - Reaching 2^TIMEOUT_W-1 triggers abort behaviour (tg_frame_reset + seq_aborted).
  - The counter clears on entry to START.
- Undefined: no watchdog logic; a hung generator holds the sequencer until abort.

Decomposition:
- Package frame_seq_pkg:
  - seq_state_t enum
  - mode constants MODE_SINGLE/MODE_BURST/MODE_CONT
  - roi_cfg_t struct (integration time + four ROI fields) used for the cfg and shadow buses
- One sub-module: seq_gap_timer, a loadable down-counter with a done flag used for GAP.

Test Plan:
- Single: cfg_mode=0, ROI 0..1/0..1, seq_start -> tg_frame_start 2 cycles later; after tg_frame_complete, seq_done=1, frames_done=1, seq_busy=0.
- Burst: mode=1, count=3, gap=5 -> exactly 3 tg_frame_start pulses, each ≥6 cycles after the prior complete; seq_done once; frames_done=3.
- Shadowing: continuous mode, change cfg_integration_time 1->7 during frame 1 -> tg_integration_time stays 1 until LOAD of frame 2, then 7.
- Stop/abort:
  - seq_stop during frame 2 of continuous -> frame 2 completes, seq_done, frames_done=2.
  - seq_abort during WAIT_DONE -> tg_frame_reset pulse, seq_aborted, no seq_done.
- Errors: row_start=5,row_end=2 -> cfg_error, no tg_frame_start; burst count=0 -> seq_done only.
- FRAME_TIMEOUT_EN, TIMEOUT_W=8, tg_frame_busy held 0 -> seq_aborted at 255 cycles in WAIT_BUSY.
